ram_1r1w_resp: RTL

Memory responder for the single-read-port / single-write-port RAM interface (`raddr_0`/`rdata_0`, `waddr_0`/`wen_0`/`wdata_0`) driven by the generated datapath controllers. It holds a word-addressed array and serves one read request and one write request per cycle, with a parameterised, fully pipelined read latency and a `rvalid_0` strobe. It also provides testbench debug read/write ports, an out-of-range error flag and access counters.

---
 rtl/ram_1r1w_resp.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_1r1w_resp.sv
// Word-addressed 1R1W memory responder with a fixed-latency read pipeline,
// debug access ports, a sticky out-of-range flag and saturating access counters.
module ram_1r1w_resp #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ren_0,
  input  logic [31:0]      raddr_0,
  output logic [WIDTH-1:0] rdata_0,
  output logic             rvalid_0,
  input  logic             wen_0,
  input  logic [31:0]      waddr_0,
  input  logic [WIDTH-1:0] wdata_0,
  input  logic             debug_write_en,
  input  logic [31:0]      debug_write_addr,
  input  logic [WIDTH-1:0] debug_write_data,
  input  logic [31:0]      debug_addr,
  output logic [WIDTH-1:0] debug_data,
  output logic             err_oob,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [WIDTH-1:0] mem [DEPTH];

  logic rd_in_range;
  logic wr_in_range;
  logic dbg_wr_in_range;
  logic dbg_rd_in_range;

  assign rd_in_range     = raddr_0 < DEPTH_W;
  assign wr_in_range     = waddr_0 < DEPTH_W;
  assign dbg_wr_in_range = debug_write_addr < DEPTH_W;
  assign dbg_rd_in_range = debug_addr < DEPTH_W;

  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] dbg_wr_idx;
  logic [AW-1:0] dbg_rd_idx;

  assign rd_idx     = raddr_0[AW-1:0];
  assign wr_idx     = waddr_0[AW-1:0];
  assign dbg_wr_idx = debug_write_addr[AW-1:0];
  assign dbg_rd_idx = debug_addr[AW-1:0];

  logic [WIDTH-1:0] rd_word;

  // Out-of-range reads still respond, with zero data.
  assign rd_word    = rd_in_range ? mem[rd_idx] : '0;
  assign debug_data = dbg_rd_in_range ? mem[dbg_rd_idx] : '0;

  logic port_write;
  logic oob_access;

  assign port_write = rst && wen_0 && wr_in_range;
  assign oob_access = (ren_0 && !rd_in_range) ||
                      (wen_0 && !wr_in_range) ||
                      (debug_write_en && !dbg_wr_in_range);

  // NOTE: the array has no reset branch; clearing it would turn the RAM into
  // flops and would also wipe contents preloaded through the debug port during reset.
  always_ff @(posedge clk) begin
    if (debug_write_en && dbg_wr_in_range) begin
      mem[dbg_wr_idx] <= debug_write_data;
    end
    // Port write is last so it wins a same-address collision with a debug write.
    if (port_write) begin
      mem[wr_idx] <= wdata_0;
    end
  end

  logic [WIDTH-1:0]        pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid;

  // NOTE: non-blocking assignments keep this a true shift register and make the
  // stage-0 capture see the array word from before this edge's write (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= ren_0;
      pipe_data[0]  <= ren_0 ? rd_word : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rdata_0  = pipe_data[READ_LATENCY-1];
  assign rvalid_0 = pipe_valid[READ_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_oob  <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (oob_access) begin
        err_oob <= 1'b1;
      end
      if (ren_0 && rd_in_range && rd_count != CNT_MAX) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wen_0 && wr_in_range && wr_count != CNT_MAX) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule
